// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every non-clock signal of the memory arbiter.
//   Instruction side : imemRen, imemaddr        -> i_ready, imemload
//   Data side        : dmmRen, dmmWen, dmmaddr, dmmstore -> d_ready, dmmload
//   RAM side         : busy_o, ramload -> Ren, Wen, ramaddr, ramstore
// modport slave  : the arbiter's view (requests in, RAM strobes/responses out).
// modport master : the requester/RAM-model view (mirror image).
interface mem_arbiter_if;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic        busy_o;
  logic [31:0] ramload;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        i_ready;
  logic        d_ready;
  logic [31:0] imemload;
  logic [31:0] dmmload;

  modport slave (
    input  imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, busy_o, ramload,
    output Ren, Wen, ramaddr, ramstore, i_ready, d_ready, imemload, dmmload
  );

  modport master (
    output imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, busy_o, ramload,
    input  Ren, Wen, ramaddr, ramstore, i_ready, d_ready, imemload, dmmload
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port RAM between an instruction fetch port
// and a data load/store port. Data has priority, but after STARVE_LIMIT data
// grants in a row while a fetch is waiting, the fetch is granted next.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave (requests, RAM strobes, ready pulses, load data)
// Each access runs IDLE -> IACC/DACC (held while busy_o) -> RESP (one cycle
// ready pulse) -> IDLE.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   store_q, store_d;
  logic [31:0]   iload_q, iload_d;
  logic [31:0]   dload_q, dload_d;
  logic          wr_q, wr_d;
  logic          instr_q, instr_d;

  logic data_req, starved, grant_d, grant_i;

  // Grant decision is only meaningful in IDLE; outside IDLE requests are ignored.
  assign data_req = bus.dmmRen | bus.dmmWen;
  assign starved  = bus.imemRen && (starve_q == LIM);
  assign grant_d  = (state_q == IDLE) && data_req && !starved;
  assign grant_i  = (state_q == IDLE) && !grant_d && bus.imemRen;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    instr_d = instr_q;
    iload_d = iload_q;
    dload_d = dload_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = DACC;
          addr_d  = bus.dmmaddr;
          store_d = bus.dmmstore;
          // Read+write together collapses to a write.
          wr_d    = bus.dmmWen;
          instr_d = 1'b0;
        end else if (grant_i) begin
          state_d = IACC;
          addr_d  = bus.imemaddr;
          wr_d    = 1'b0;
          instr_d = 1'b1;
        end
      end
      IACC: begin
        if (!bus.busy_o) begin
          iload_d = bus.ramload;
          state_d = RESP;
        end
      end
      DACC: begin
        if (!bus.busy_o) begin
          if (!wr_q) dload_d = bus.ramload;
          state_d = RESP;
        end
      end
      default: state_d = IDLE; // RESP lasts exactly one cycle
    endcase
  end

  // Starve counter: counts data grants that jumped a waiting fetch; any IDLE
  // cycle without a pending fetch, or a fetch grant, restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (grant_i || !bus.imemRen)
        starve_d = '0;
      else if (grant_d && (starve_q != LIM))
        starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      instr_q  <= 1'b0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      instr_q  <= instr_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
    end
  end

  // Strobes decode straight from state so reset clears them immediately.
  assign bus.Ren      = (state_q == IACC) || ((state_q == DACC) && !wr_q);
  assign bus.Wen      = (state_q == DACC) && wr_q;
  assign bus.i_ready  = (state_q == RESP) && instr_q;
  assign bus.d_ready  = (state_q == RESP) && !instr_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.imemload = iload_q;
  assign bus.dmmload  = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- scoreboard bench for mem_arbiter. Stimulus pushes the
// expected access (kind, address, store data, load value, strobe cycles) into
// exp_q in the order the arbiter must serve them; a monitor compares every
// strobe cycle and every ready pulse against the head of the queue.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if ar();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ar.slave)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
  } dreq_t;

  typedef struct {
    bit          instr;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    int          ncyc;
  } exp_t;

  exp_t        exp_q[$];
  dreq_t       dq[$];
  logic [31:0] iq[$];

  int checks = 0;
  int fails  = 0;
  int tmo_req = 0;
  int tmo_ack = 0;

  // RAM model: read data is a fixed word or the address with upper bits flipped.
  bit          use_fixed = 1'b0;
  logic [31:0] rl_fixed  = 32'h0;
  int          bwait     = 0;
  int          acc_cnt   = 0;
  assign ar.ramload = use_fixed ? rl_fixed : (ar.ramaddr ^ 32'hF0F0_0000);

  // busy_o stays high for the first bwait cycles of each strobed access.
  always @(negedge CLK) begin
    if (ar.Ren || ar.Wen) begin
      ar.busy_o = (acc_cnt < bwait);
      acc_cnt++;
    end else begin
      ar.busy_o = 1'b0;
      acc_cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor
  bit   in_acc = 1'b0;
  int   ncyc   = 0;
  exp_t e;
  always @(negedge CLK) begin
    if (tmo_req != tmo_ack) begin
      checks++;
      fails++;
      $display("FAIL timeout waiting for responses, pending=%0d", exp_q.size());
      tmo_ack = tmo_req;
    end
    if (RST) begin
      chk("rst_Ren", 32'(ar.Ren), 32'h0);
      chk("rst_Wen", 32'(ar.Wen), 32'h0);
      chk("rst_i_ready", 32'(ar.i_ready), 32'h0);
      chk("rst_d_ready", 32'(ar.d_ready), 32'h0);
      chk("rst_ramaddr", ar.ramaddr, 32'h0);
      chk("rst_ramstore", ar.ramstore, 32'h0);
      chk("rst_imemload", ar.imemload, 32'h0);
      chk("rst_dmmload", ar.dmmload, 32'h0);
      // An access cut short by reset never completes.
      if (in_acc && exp_q.size() > 0) exp_q.delete(0);
      in_acc = 1'b0;
      ncyc   = 0;
    end else begin
      if (ar.Ren || ar.Wen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {30'h0, ar.Ren, ar.Wen}, 32'h0);
        end else begin
          e = exp_q[0];
          in_acc = 1'b1;
          ncyc++;
          chk("strobe_kind", {30'h0, ar.Ren, ar.Wen}, e.wr ? 32'h1 : 32'h2);
          chk("ramaddr", ar.ramaddr, e.addr);
          if (e.wr) chk("ramstore", ar.ramstore, e.store);
        end
      end
      if (ar.i_ready || ar.d_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", {30'h0, ar.i_ready, ar.d_ready}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("ready_kind", {30'h0, ar.i_ready, ar.d_ready}, e.instr ? 32'h2 : 32'h1);
          chk("resp_strobes", {30'h0, ar.Ren, ar.Wen}, 32'h0);
          chk("strobe_cycles", ncyc, e.ncyc);
          if (e.instr) chk("imemload", ar.imemload, e.load);
          else         chk("dmmload", ar.dmmload, e.load);
        end
        in_acc = 1'b0;
        ncyc   = 0;
      end
    end
  end

  // Stimulus helpers
  task automatic push_exp(input bit instr, input bit wr, input logic [31:0] addr,
                          input logic [31:0] store, input logic [31:0] load, input int n);
    exp_t x;
    x.instr = instr; x.wr = wr; x.addr = addr; x.store = store; x.load = load; x.ncyc = n;
    exp_q.push_back(x);
  endtask

  task automatic present_d();
    dreq_t r;
    if (dq.size() > 0) begin
      r = dq.pop_front();
      ar.dmmRen = r.rd; ar.dmmWen = r.wr; ar.dmmaddr = r.addr; ar.dmmstore = r.store;
    end else begin
      ar.dmmRen = 1'b0; ar.dmmWen = 1'b0;
    end
  endtask

  task automatic present_i();
    if (iq.size() > 0) begin
      ar.imemRen = 1'b1; ar.imemaddr = iq.pop_front();
    end else begin
      ar.imemRen = 1'b0;
    end
  endtask

  task automatic add_d(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] s);
    dreq_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.store = s;
    dq.push_back(r);
  endtask

  // Requests are held until their ready pulse, then replaced or dropped.
  task automatic step();
    @(negedge CLK);
    if (ar.d_ready) present_d();
    if (ar.i_ready) present_i();
  endtask

  task automatic kick();
    if (!(ar.dmmRen || ar.dmmWen)) present_d();
    if (!ar.imemRen) present_i();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      tmo_req++;
      exp_q.delete(); dq.delete(); iq.delete();
      ar.imemRen = 1'b0; ar.dmmRen = 1'b0; ar.dmmWen = 1'b0;
    end
    step();
    step();
  endtask

  initial begin
    ar.imemRen = 1'b0; ar.imemaddr = '0;
    ar.dmmRen = 1'b0; ar.dmmWen = 1'b0; ar.dmmaddr = '0; ar.dmmstore = '0;
    ar.busy_o = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;
    step();

    // Single fetch, fixed read word.
    use_fixed = 1'b1; rl_fixed = 32'hDEAD_BEEF; bwait = 0;
    push_exp(1, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
    iq.push_back(32'h100);
    kick();
    wait_done(20);
    use_fixed = 1'b0;

    // Contention: data first, then the fetch.
    push_exp(0, 0, 32'h200, 32'h0, 32'hF0F0_0200, 1);
    push_exp(1, 0, 32'h300, 32'h0, 32'hF0F0_0300, 1);
    add_d(1, 0, 32'h200, 32'h0);
    iq.push_back(32'h300);
    kick();
    wait_done(20);

    // Write with 3 busy cycles; inputs change and request drops mid-access.
    bwait = 3;
    push_exp(0, 1, 32'h40, 32'h1234_5678, 32'hF0F0_0200, 4);
    add_d(0, 1, 32'h40, 32'h1234_5678);
    kick();
    step();
    ar.dmmaddr = 32'hBAD; ar.dmmstore = 32'h0;
    step();
    ar.dmmWen = 1'b0;
    wait_done(20);

    // Both strobes -> write only; then a plain read.
    bwait = 1;
    push_exp(0, 1, 32'h44, 32'hCAFE_F00D, 32'hF0F0_0200, 2);
    add_d(1, 1, 32'h44, 32'hCAFE_F00D);
    kick();
    wait_done(20);
    bwait = 0;
    push_exp(0, 0, 32'h80, 32'h0, 32'hF0F0_0080, 1);
    add_d(1, 0, 32'h80, 32'h0);
    kick();
    wait_done(20);

    // Starvation: 4 data, fetch, 4 data (counter restarted), fetch, last data.
    for (int k = 0; k < 9; k++) begin
      add_d(1, 0, 32'h1000 + 32'(4 * k), 32'h0);
    end
    iq.push_back(32'h500);
    iq.push_back(32'h504);
    for (int k = 0; k < 9; k++) begin
      if (k == 4) push_exp(1, 0, 32'h500, 32'h0, 32'hF0F0_0500, 1);
      if (k == 8) push_exp(1, 0, 32'h504, 32'h0, 32'hF0F0_0504, 1);
      push_exp(0, 0, 32'h1000 + 32'(4 * k), 32'h0, 32'hF0F0_1000 + 32'(4 * k), 1);
    end
    kick();
    wait_done(100);

    // Reset in the middle of a stalled fetch.
    bwait = 1000;
    push_exp(1, 0, 32'h600, 32'h0, 32'h0, 1001);
    iq.push_back(32'h600);
    kick();
    step(); step(); step();
    @(posedge CLK);
    #2 RST = 1'b1;
    ar.imemRen = 1'b0;
    bwait = 0;
    @(negedge CLK);
    #1 RST = 1'b0;
    step(); step(); step();

    // Served normally after reset.
    push_exp(1, 0, 32'h700, 32'h0, 32'hF0F0_0700, 1);
    iq.push_back(32'h700);
    kick();
    wait_done(20);

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_LIMIT, default 4: max consecutive data grants while an instruction request waits.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imemRen  input  1  instruction fetch request, held high until i_ready.
REQ-005 SHALL have port imemaddr  input  32  instruction fetch address.
REQ-006 SHALL have ports dmmRen, dmmWen  input  1 each  data read / write request, held high until d_ready.
REQ-007 SHALL have ports dmmaddr, dmmstore  input  32 each  data address / write data.
REQ-008 SHALL have port busy_o  input  1  RAM busy; access completes in the first active cycle with busy_o=0.
REQ-009 SHALL have port ramload  input  32  RAM read data, valid when busy_o=0.
REQ-010 SHALL have ports Ren, Wen  output  1 each  RAM read / write strobes.
REQ-011 SHALL have ports ramaddr, ramstore  output  32 each  RAM address / write data.
REQ-012 SHALL have ports i_ready, d_ready  output  1 each  one-cycle completion pulses.
REQ-013 SHALL have ports imemload, dmmload  output  32 each  registered read data.

Function
REQ-014 SHALL implement FSM states IDLE, IACC, DACC, RESP.
REQ-015 IDLE: no request -> stay; data request pending (dmmRen|dmmWen) and STARVE_LIMIT not reached -> latch dmmaddr, dmmstore and op type, go DACC; else imemRen -> latch imemaddr, go IACC.
REQ-016 Priority: data over instruction, except when the starve counter equals STARVE_LIMIT and imemRen=1 -> instruction granted.
REQ-017 Starve counter: +1 on each data grant while imemRen=1; cleared on instruction grant, and on any IDLE cycle with imemRen=0; saturates at STARVE_LIMIT.
REQ-018 dmmRen and dmmWen both high: SHALL be treated as a write; no read occurs.
REQ-019 IACC: Ren=1, Wen=0, ramaddr=latched address; busy_o=1 -> stay; busy_o=0 -> imemload<=ramload, go RESP.
REQ-020 DACC read: Ren=1, Wen=0; busy_o=0 -> dmmload<=ramload, go RESP.
REQ-021 DACC write: Wen=1, Ren=0, ramstore=latched store data; busy_o=0 -> go RESP; dmmload unchanged.
REQ-022 RESP: exactly one cycle; i_ready=1 (instruction access) or d_ready=1 (data access); Ren=Wen=0; requests ignored; then IDLE.
REQ-023 Minimum latency: request sampled in IDLE at edge N, strobe in cycle N+1, ready pulse in cycle N+2 if busy_o=0 in cycle N+1.
REQ-024 Ren and Wen SHALL never be high together; neither is high in IDLE or RESP.
REQ-025 Address/data SHALL be latched at grant; input changes during IACC/DACC SHALL NOT affect ramaddr/ramstore.
REQ-026 A request withdrawn mid-access SHALL NOT abort it; access completes and the ready pulse is still issued.
REQ-027 ramaddr/ramstore SHALL hold last latched values in IDLE/RESP; only Ren/Wen qualify them.
REQ-028 imemload/dmmload SHALL hold their value until the next completed read of the same type.
REQ-029 No watchdog: busy_o stuck high SHALL hold IACC/DACC indefinitely.

Reset
REQ-030 RST=1 SHALL immediately force state IDLE, starve counter 0, and Ren, Wen, i_ready, d_ready, ramaddr, ramstore, imemload, dmmload all 0.
REQ-031 Reset mid-access SHALL abandon the access with no ready pulse; first grant is evaluated on the first edge after RST falls.

Verification
REQ-032 Single fetch: imemRen=1, imemaddr=0x100, busy_o=0, ramload=0xDEADBEEF -> Ren=1 with ramaddr=0x100 for one cycle; next cycle i_ready=1, imemload=0xDEADBEEF.
REQ-033 Contention: imemRen=1 and dmmRen=1 together, dmmaddr=0x200 -> data served first (ramaddr=0x200, d_ready), then instruction (ramaddr=imemaddr, i_ready).
REQ-034 Starvation: imemRen held high, data requests re-issued back-to-back, STARVE_LIMIT=4 -> 4 data grants, then instruction grant, then counter 0.
REQ-035 Write with wait: dmmWen=1, dmmaddr=0x40, dmmstore=0x12345678, busy_o high 3 cycles -> Wen=1, ramstore=0x12345678 for 4 cycles, then d_ready pulse; dmmload unchanged.
REQ-036 Reset mid-access: RST pulsed during IACC with busy_o=1 -> all outputs 0 at once, no i_ready; a new request after RST falls is served normally.
REQ-037 Both strobes: dmmRen=dmmWen=1 -> Wen=1, Ren=0 for the whole access.
